// File: rtl/layer_pkg.sv
// Shared types and defaults for the argmax output layer.
// Holds the FSM state encoding and default frame geometry.
package layer_pkg;

  localparam int T_DEF = 9;
  localparam int M_DEF = 5;

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_t;

endpackage

// File: rtl/argmax_datapath.sv
// Running max/index tracker with a signed comparator.
// Final frame result is latched into dedicated output registers.
module argmax_datapath #(
  parameter int T    = 9,
  parameter int LOGM = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_acc,
  input  logic                i_first,
  input  logic                i_last,
  input  logic [LOGM-1:0]     i_idx,
  input  logic signed [T-1:0] i_data,
  output logic signed [T-1:0] o_max,
  output logic [LOGM-1:0]     o_idx
);

  logic signed [T-1:0] r_max;
  logic [LOGM-1:0]     r_idx;
  logic signed [T-1:0] r_dout;
  logic [LOGM-1:0]     r_iout;

  logic                w_upd;
  logic signed [T-1:0] w_nmax;
  logic [LOGM-1:0]     w_nidx;

  // strict greater-than keeps the earliest index on ties
  assign w_upd  = i_first || (i_data > r_max);
  assign w_nmax = w_upd ? i_data : r_max;
  assign w_nidx = w_upd ? i_idx : r_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_max  <= '0;
      r_idx  <= '0;
      r_dout <= '0;
      r_iout <= '0;
    end else if (i_acc) begin
      r_max <= w_nmax;
      r_idx <= w_nidx;
      if (i_last) begin
        r_dout <= w_nmax;
        r_iout <= w_nidx;
      end
    end
  end

  assign o_max = r_dout;
  assign o_idx = r_iout;

endmodule

// File: rtl/layer_argmax.sv
// Argmax output layer: collects M activations, presents max and index.
// Two-state FSM with a frame counter; datapath held in argmax_datapath.
module layer_argmax
  import layer_pkg::*;
#(
  parameter int T    = T_DEF,
  parameter int M    = M_DEF,
  parameter int LOGM = $clog2(M)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [T-1:0] data_in,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [T-1:0] data_out,
  output logic [LOGM-1:0]     idx_out
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [LOGM-1:0] r_cnt;
  logic [LOGM-1:0] w_cnt_nxt;
  logic            r_live;

  logic w_acc;
  logic w_first;
  logic w_last;

  // r_live keeps s_ready low until the first edge after reset
  assign s_ready = r_live && (r_state == COLLECT);
  assign m_valid = (r_state == OUTPUT);

  assign w_acc   = s_valid && s_ready;
  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == LOGM'(M - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= COLLECT;
      r_cnt   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      COLLECT: begin
        if (w_acc) begin
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = OUTPUT;
          end else begin
            w_cnt_nxt = r_cnt + LOGM'(1);
          end
        end
      end
      OUTPUT: begin
        if (m_ready) w_state_nxt = COLLECT;
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  argmax_datapath #(
    .T    (T),
    .LOGM (LOGM)
  ) u_dp (
    .clk     (clk),
    .reset   (reset),
    .i_acc   (w_acc),
    .i_first (w_first),
    .i_last  (w_last),
    .i_idx   (r_cnt),
    .i_data  (data_in),
    .o_max   (data_out),
    .o_idx   (idx_out)
  );

endmodule

// File: tb/tb_layer_argmax.sv
// Directed bench for layer_argmax with hand-computed expectations.
// Inputs change 1 ns after each rising edge; outputs sampled there too.
module tb_layer_argmax;

  logic              clk;
  logic              reset;
  logic              s_valid;
  logic              s_ready;
  logic signed [8:0] data_in;
  logic              m_valid;
  logic              m_ready;
  logic signed [8:0] data_out;
  logic [2:0]        idx_out;

  int checks = 0;
  int errors = 0;

  logic signed [8:0] fr [5];
  logic              pv [8];
  logic signed [8:0] pd [8];

  layer_argmax dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .data_out (data_out),
    .idx_out  (idx_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic feed();
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      data_in = fr[i];
      tick();
    end
    s_valid = 1'b0;
    data_in = '0;
  endtask

  task automatic result(input string tag,
                        input int d,
                        input int ix);
    chk({tag, "_mv"}, m_valid, 1);
    chk({tag, "_sr"}, s_ready, 0);
    chk({tag, "_d"}, data_out, d);
    chk({tag, "_i"}, idx_out, ix);
  endtask

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    data_in = '0;
    m_ready = 1'b1;
    #12;
    chk("rst_sr", s_ready, 0);
    chk("rst_mv", m_valid, 0);
    chk("rst_d", data_out, 0);
    chk("rst_i", idx_out, 0);
    reset = 1'b0;
    #1;
    chk("rel_sr", s_ready, 0);
    tick();
    chk("live_sr", s_ready, 1);

    // frame 3,7,-2,7,1 with latency check
    fr = '{3, 7, -2, 7, 1};
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("f1_pre_mv", m_valid, 0);
      s_valid = 1'b1;
      data_in = fr[i];
      tick();
    end
    s_valid = 1'b0;
    result("f1", 7, 1);
    tick();
    chk("f1_back_sr", s_ready, 1);
    chk("f1_back_mv", m_valid, 0);

    // signed compare and tie rule
    fr = '{-5, -3, -9, -3, -100};
    feed();
    result("f2", -3, 1);
    tick();

    // backpressure: hold for 4 cycles, s_valid ignored meanwhile
    m_ready = 1'b0;
    fr = '{0, 0, 0, 0, 255};
    feed();
    s_valid = 1'b1;
    data_in = 9'sd100;
    for (int i = 0; i < 4; i++) begin
      result("f3_hold", 255, 4);
      tick();
    end
    s_valid = 1'b0;
    result("f3_end", 255, 4);
    m_ready = 1'b1;
    tick();
    chk("f3_back_sr", s_ready, 1);
    chk("f3_back_mv", m_valid, 0);

    // gaps in s_valid; stalled data must not leak in
    pv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    pd = '{2, 127, 127, 9, 4, 127, 1, 8};
    for (int i = 0; i < 8; i++) begin
      s_valid = pv[i];
      data_in = pd[i];
      tick();
    end
    s_valid = 1'b0;
    result("f4", 9, 1);
    tick();

    // mid-frame reset discards partial data
    fr = '{50, 60, 70, 0, 0};
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      data_in = fr[i];
      tick();
    end
    s_valid = 1'b0;
    reset = 1'b1;
    #2;
    chk("mrst_sr", s_ready, 0);
    chk("mrst_d", data_out, 0);
    reset = 1'b0;
    tick();
    chk("mrst_live", s_ready, 1);
    fr = '{1, 2, 3, 4, 5};
    feed();
    result("f5", 5, 4);
    tick();
    chk("f5_back_sr", s_ready, 1);

    // back-to-back frames, single idle cycle on s_ready
    fr = '{10, -20, 30, 30, -1};
    feed();
    result("f6", 30, 2);
    tick();
    chk("f6_turn_sr", s_ready, 1);
    fr = '{-1, -1, -1, -1, -1};
    feed();
    result("f7", -1, 0);
    tick();
    chk("f7_back_sr", s_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
